// File: rtl/ps2_pkg.sv
// ps2_pkg: shared prefix constants, frame length and receiver FSM state encoding.
package ps2_pkg;
    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 11;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
endpackage

// File: rtl/ps2_scancode_receiver_if.sv
// ps2_scancode_receiver_if: raw PS/2 pins in, qualified scan-code events and error pulses out.
interface ps2_scancode_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid;
    logic       is_extended;
    logic       is_break;
    logic       parity_err;
    logic       frame_err;
    modport master (output ps2_clk, ps2_data,
                    input  code, code_valid, is_extended, is_break, parity_err, frame_err);
    modport slave  (input  ps2_clk, ps2_data,
                    output code, code_valid, is_extended, is_break, parity_err, frame_err);
endinterface

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: synchronises the PS/2 pins and detects ps2_clk falling edges.
// Define PS2_GLITCH_FILTER_EN to require FILTER_LEN stable low cycles per edge.
module ps2_edge_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_pulse,
    output logic data_sync
);
    logic [1:0] clk_sync, dat_sync;
    always_ff @(posedge clk)
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    assign data_sync = dat_sync[1];
`ifdef PS2_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] low_cnt;
    // Saturating low-time counter; the edge fires once, on the FILTER_LEN-th low cycle.
    always_ff @(posedge clk)
        if (rst || clk_sync[1]) low_cnt <= '0;
        else if (low_cnt != CW'(FILTER_LEN)) low_cnt <= low_cnt + 1'b1;
    assign fall_pulse = !clk_sync[1] && low_cnt == CW'(FILTER_LEN - 1);
`else
    logic clk_prev;
    always_ff @(posedge clk) clk_prev <= rst ? 1'b1 : clk_sync[1];
    assign fall_pulse = clk_prev && !clk_sync[1];
`endif
endmodule

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver: PS/2 frame deserialiser with E0/F0 prefix resolution.
// Optional glitch filter on ps2_clk enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 8
) (
    input logic clk,
    input logic rst,
    ps2_scancode_receiver_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic          fall, din;
    ps2_state_t    state, state_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n, code_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          par_ok, par_ok_n, ext_pend, ext_n, brk_pend, brk_n;
    logic          is_ext_n, is_brk_n, valid_n, perr_n, ferr_n;

    ps2_edge_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk(clk), .rst(rst), .ps2_clk(bus.ps2_clk), .ps2_data(bus.ps2_data),
        .fall_pulse(fall), .data_sync(din)
    );

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_ok_n = par_ok;
        ext_n    = ext_pend;
        brk_n    = brk_pend;
        code_n   = bus.code;
        is_ext_n = bus.is_extended;
        is_brk_n = bus.is_break;
        valid_n  = 1'b0;
        perr_n   = 1'b0;
        ferr_n   = 1'b0;
        tcnt_n   = (state == IDLE || fall) ? '0 : tcnt + 1'b1;
        if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
            tcnt_n  = '0;
        end else if (fall) begin
            case (state)
                IDLE: if (!din) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                    shreg_n  = '0;
                end
                DATA: begin
                    shreg_n[bitcnt] = din;
                    bitcnt_n        = bitcnt + 1'b1;
                    state_n         = (bitcnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_ok_n = ^{shreg, din};
                    state_n  = STOP;
                end
                default: begin
                    state_n = IDLE;
                    // A bad stop bit outranks a parity failure; either drops pending prefixes.
                    if (!din || !par_ok) begin
                        ferr_n = !din;
                        perr_n = din;
                        ext_n  = 1'b0;
                        brk_n  = 1'b0;
                    end else if (shreg == PS2_PREFIX_EXT) ext_n = 1'b1;
                    else if (shreg == PS2_PREFIX_BREAK) brk_n = 1'b1;
                    else begin
                        code_n   = shreg;
                        is_ext_n = ext_pend;
                        is_brk_n = brk_pend;
                        valid_n  = 1'b1;
                        ext_n    = 1'b0;
                        brk_n    = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk)
        if (rst) begin
            state           <= IDLE;
            bitcnt          <= '0;
            shreg           <= '0;
            tcnt            <= '0;
            par_ok          <= 1'b0;
            ext_pend        <= 1'b0;
            brk_pend        <= 1'b0;
            bus.code        <= '0;
            bus.is_extended <= 1'b0;
            bus.is_break    <= 1'b0;
            bus.code_valid  <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            state           <= state_n;
            bitcnt          <= bitcnt_n;
            shreg           <= shreg_n;
            tcnt            <= tcnt_n;
            par_ok          <= par_ok_n;
            ext_pend        <= ext_n;
            brk_pend        <= brk_n;
            bus.code        <= code_n;
            bus.is_extended <= is_ext_n;
            bus.is_break    <= is_brk_n;
            bus.code_valid  <= valid_n;
            bus.parity_err  <= perr_n;
            bus.frame_err   <= ferr_n;
        end
endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver: randomized PS/2 frames against a byte-level scoreboard model.
module tb_ps2_scancode_receiver;
    import ps2_pkg::*;
    localparam int TIMEOUT = 2000;
    localparam int FLEN    = 8;
    localparam int HALF    = 20;
`ifdef PS2_GLITCH_FILTER_EN
    localparam int LAT = 3 + FLEN - 1;
`else
    localparam int LAT = 3;
`endif
    typedef struct {
        logic [2:0] pulses;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        bit         timed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0, last_fall = 0, passed = 0, total = 0;
    bit   ext_m, brk_m;
    exp_t q[$];

    ps2_scancode_receiver_if bus();
    ps2_scancode_receiver #(.TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(FLEN)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        int   n;
        exp_t e;
        if (!rst) begin
            n = int'(bus.code_valid) + int'(bus.parity_err) + int'(bus.frame_err);
            if (n > 0) begin
                check("single_pulse", n, 1);
                if (q.size() == 0) check("unexpected_pulse", {bus.code_valid, bus.parity_err, bus.frame_err}, 0);
                else begin
                    e = q.pop_front();
                    check("pulse_kind", {bus.code_valid, bus.parity_err, bus.frame_err}, e.pulses);
                    if (e.pulses == 3'b100) begin
                        check("code", bus.code, e.code);
                        check("is_extended", bus.is_extended, e.ext);
                        check("is_break", bus.is_break, e.brk);
                    end
                    if (e.timed) check("latency", cyc - last_fall, LAT);
                end
            end
        end
    end

    // Byte-level reference: prefixes accumulate, any error or emitted code clears them.
    task automatic model(input logic [7:0] b, input int err);
        if (err == 2) q.push_back('{pulses: 3'b001, code: 8'h00, ext: 1'b0, brk: 1'b0, timed: 1'b1});
        else if (err == 1) q.push_back('{pulses: 3'b010, code: 8'h00, ext: 1'b0, brk: 1'b0, timed: 1'b1});
        else if (b == PS2_PREFIX_EXT) ext_m = 1'b1;
        else if (b == PS2_PREFIX_BREAK) brk_m = 1'b1;
        else q.push_back('{pulses: 3'b100, code: b, ext: ext_m, brk: brk_m, timed: 1'b1});
        if (err != 0 || (b != PS2_PREFIX_EXT && b != PS2_PREFIX_BREAK)) begin
            ext_m = 1'b0;
            brk_m = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            if (glitch && i == 3) begin
                repeat (HALF / 2) @(negedge clk);
                bus.ps2_clk = 1'b0;
                repeat (2) @(negedge clk);
                bus.ps2_clk = 1'b1;
                repeat (HALF - HALF / 2 - 2) @(negedge clk);
            end else repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input int err);
        logic p, stop;
        p    = (err == 1) ? ^b : ~^b;
        stop = (err == 2) ? 1'b0 : 1'b1;
        return {stop, p, b, 1'b0};
    endfunction

    task automatic frame(input logic [7:0] b, input int err, input bit glitch);
        model(b, err);
        send_bits(make_frame(b, err), PS2_FRAME_BITS, glitch);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_code"}, bus.code, 8'h00);
        check({tag, "_ext"}, bus.is_extended, 1'b0);
        check({tag, "_brk"}, bus.is_break, 1'b0);
        check({tag, "_valid"}, bus.code_valid, 1'b0);
        check({tag, "_perr"}, bus.parity_err, 1'b0);
        check({tag, "_ferr"}, bus.frame_err, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        int         r, err;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        frame(8'h1D, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'h1D, 1, 0);
        frame(8'h5A, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h5A, 2, 0);
        frame(8'h2A, 0, 0);
        frame(8'hE1, 0, 0);
        frame(8'hE0, 0, 0);
        q.push_back('{pulses: 3'b001, code: 8'h00, ext: 1'b0, brk: 1'b0, timed: 1'b0});
        ext_m = 1'b0;
        brk_m = 1'b0;
        send_bits(make_frame(8'h33, 0), 5, 0);
        repeat (TIMEOUT + 10) @(negedge clk);
        frame(8'h6B, 0, 0);
        frame(8'h12, 0, 0);
        frame(8'hF0, 0, 0);
        send_bits(make_frame(8'h44, 0), 4, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("mid_reset");
        ext_m = 1'b0;
        brk_m = 1'b0;
        repeat (100) @(negedge clk);
        frame(8'h1C, 0, 0);
`ifdef PS2_GLITCH_FILTER_EN
        bus.ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        frame(8'h29, 0, 1);
`endif
        for (int i = 0; i < 40; i++) begin
            r   = $urandom_range(0, 9);
            b   = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
            r   = $urandom_range(0, 9);
            err = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            frame(b, err, 0);
        end
        repeat (50) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks", passed, total);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ps2_scancode_receiver.md
Name: ps2_scancode_receiver

Overview:
Upstream stage of the keyboard path. Deserialises PS/2 device-to-host frames from the raw ps2_clk/ps2_data pins and resolves the E0 (extended) and F0 (break) prefixes. Emits one qualified scan-code byte per key event with flags, as a single-cycle valid pulse. The downstream keyboard control block consumes it and maps keys to up/left/right/enter.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles allowed between successive ps2_clk falling edges mid-frame before abort (1 ms at 100 MHz).
FILTER_LEN, 8, clk cycles ps2_clk must be stably low to count as a falling edge; used only when PS2_GLITCH_FILTER_EN is defined.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock, asynchronous to clk
ps2_data  input  1  raw PS/2 data, asynchronous to clk
code  output  8  scan code of the last emitted event; held between events
code_valid  output  1  one-cycle pulse; code/is_extended/is_break valid this cycle
is_extended  output  1  event was preceded by E0
is_break  output  1  event was preceded by F0 (key release)
parity_err  output  1  one-cycle pulse on odd-parity failure
frame_err  output  1  one-cycle pulse on bad stop bit or timeout

Behaviour:
- Reset (sync, rst=1 at clk edge): code=8'h00, all flags and pulses 0, FSM=IDLE, shift register, bit counter, timeout counter and prefix flags cleared. Reset mid-frame discards the partial frame with no error pulse.
- Synchronisation: ps2_clk and ps2_data each pass through a 2-flop synchroniser. A falling edge is detected when the synced clock goes from 1 to 0. Data is sampled on the detect cycle.
- Frame: start(0), 8 data bits LSB first, odd parity, stop(1). That is 11 falling edges.
- FSM states and transitions:
  - IDLE: on an edge with data=0, go to DATA and set bitcnt=0. On an edge with data=1, stay in IDLE (glitch, no error).
  - DATA: each edge shifts the data bit into bit[bitcnt]. After the 8th bit, go to PARITY.
  - PARITY: check that XOR(data byte, parity bit)=1. Latch the result and go to STOP.
  - STOP: if stop=0, pulse frame_err and go to IDLE. Otherwise, on parity failure pulse parity_err and go to IDLE. Otherwise process the byte and go to IDLE.
- Timeout: the counter runs in any state other than IDLE and clears on each edge. When it reaches TIMEOUT_CYCLES, pulse frame_err, go to IDLE, and discard the partial byte.
- Byte processing:
  - 8'hE0: set ext_pending; no output.
  - 8'hF0: set brk_pending; no output.
  - Any other byte, including E1: drive code=byte, is_extended=ext_pending, is_break=brk_pending, and pulse code_valid. Clear both pending flags in the same cycle.
- Any error pulse or timeout also clears both pending flags.
- Latency: code_valid is asserted exactly 1 clk after the synced stop-bit falling edge is detected. That is 3 clk after the raw pin edge, filter disabled.
- is_extended/is_break hold their values until the next code_valid, matching code.
- Error and valid pulses are mutually exclusive within one frame. No two pulses occur in the same cycle.
- Host-to-device transmission (inhibit) is out of scope. A host pulling ps2_clk low produces no data edges and is handled by timeout.

Optional Feature:
PS2_GLITCH_FILTER_EN:
- Defined: a saturating counter requires the synced ps2_clk to be low for FILTER_LEN consecutive clk cycles before a falling edge is declared. Shorter low pulses are ignored. Latency grows by FILTER_LEN-1 cycles.
- Undefined: the plain 1→0 detect on the synced clock is used, and FILTER_LEN is unused.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0, PS2_FRAME_BITS=11;
  - the FSM state encoding (IDLE, DATA, PARITY, STOP).
- Sub-module ps2_edge_sync handles the synchronisers, the optional glitch filter and falling-edge detection. Its outputs are fall_pulse and data_sync.
- The FSM, timeout counter and prefix logic stay in the top-level block.

Test Plan:
- Frame 0x1D with correct parity (p=1) at 12.5 kHz → one code_valid, code=8'h1D, is_extended=0, is_break=0, no error pulses.
- Frames E0, F0, 0x75 → a single code_valid with code=8'h75, is_extended=1, is_break=1. A following plain frame 0x75 → is_extended=0, is_break=0.
- Frame 0x1D with the parity bit flipped → parity_err pulse, no code_valid. A following frame 0x5A → code=8'h5A with flags 0 (pending flags cleared).
- Frame 0x5A with stop bit 0 → frame_err pulse, no code_valid, FSM back in IDLE. The next valid frame is received correctly.
- 5 bits of a frame, then silence of TIMEOUT_CYCLES+10 → exactly one frame_err. rst asserted for 1 cycle mid-frame → all outputs 0 and no pulse, then a clean frame decodes.
- With PS2_GLITCH_FILTER_EN: 2-cycle low glitches injected on ps2_clk during IDLE and DATA → ignored, and frame 0x29 decodes as code=8'h29.
